// File: rtl/data_mem_responder_pkg.sv
// Shared RV32I memory-access constants and types.
// Used by the data memory responder and the main decoder.
package rv32i_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        flt;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core <-> data memory request/response bundle.
// master = core side, slave = memory responder.
interface data_mem_responder_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemStall;
  logic        MemFault;

  modport master (
    output MemRead, MemWrite, Addr,
    output WriteData, Funct3,
    input  ReadData, MemReady,
    input  MemStall, MemFault
  );

  modport slave (
    input  MemRead, MemWrite, Addr,
    input  WriteData, Funct3,
    output ReadData, MemReady,
    output MemStall, MemFault
  );

endinterface

// File: rtl/data_mem_responder_load_align.sv
// Load lane select and sign/zero extension.
// Pure combinational: RAM word + byte offset + funct3 -> result.
module mem_load_align
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{lane, 3'b000} +: 8];
    h      = lane[1] ? word[31:16] : word[15:0];
    result = word;
    unique case (1'b1)
      (funct3 == F3_B):  result = {{24{b[7]}}, b};
      (funct3 == F3_BU): result = {24'd0, b};
      (funct3 == F3_H):  result = {{16{h[15]}}, h};
      (funct3 == F3_HU): result = {16'd0, h};
      default:           result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder for RV32I loads/stores.
// Fixed two-cycle access with fault detection at capture.
module data_mem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] ram [DEPTH];

  state_t                state, nstate;
  req_t                  req_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           rdata_q;
  logic                  ready_q, fault_q;

  logic                  fault, hi_bad, cap;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wrep, aligned;
  logic [ADDR_WIDTH-1:0] idx;
  logic [2:0]            f3;

  assign f3     = bus.Funct3;
  assign hi_bad = |(bus.Addr >> (ADDR_WIDTH + 2));
  assign cap    = (state == IDLE) &
                  (bus.MemRead | bus.MemWrite);

  always_comb begin
    fault = hi_bad;
    if (bus.MemRead & bus.MemWrite)
      fault = 1'b1;
    if (bus.MemRead &
        !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      fault = 1'b1;
    if (bus.MemWrite & !(f3 inside {F3_B, F3_H, F3_W}))
      fault = 1'b1;
    if ((f3 == F3_H || f3 == F3_HU) & bus.Addr[0])
      fault = 1'b1;
    if ((f3 == F3_W) & (bus.Addr[1:0] != 2'b00))
      fault = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      (state == IDLE):   if (cap) nstate = ACCESS;
      (state == ACCESS): nstate = DONE;
      default:           nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      addr_q <= '0;
    end else if (cap) begin
      req_q  <= '{rd: bus.MemRead, wr: bus.MemWrite,
                  flt: fault, f3: f3,
                  wdata: bus.WriteData};
      addr_q <= bus.Addr[ADDR_WIDTH+1:0];
    end
  end

  assign idx   = addr_q[ADDR_WIDTH+1:2];
  assign wr_en = (state == ACCESS) & req_q.wr & ~req_q.flt;

  always_comb begin
    be   = 4'b1111;
    wrep = req_q.wdata;
    unique case (1'b1)
      (req_q.f3 == F3_B): begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {4{req_q.wdata[7:0]}};
      end
      (req_q.f3 == F3_H): begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_q.wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  mem_load_align u_align (
    .word   (ram[idx]),
    .lane   (addr_q[1:0]),
    .funct3 (req_q.f3),
    .result (aligned)
  );

  // Result is latched on leaving ACCESS and held until the next DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (state == ACCESS) begin
      rdata_q <= (req_q.rd & ~req_q.flt) ? aligned : '0;
      ready_q <= 1'b1;
      fault_q <= req_q.flt;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;
  assign bus.MemFault = fault_q;
  assign bus.MemStall = (bus.MemRead | bus.MemWrite) & ~ready_q;

endmodule
